// File: rtl/core_pkg.sv
// Shared core definitions: data widths, default reset vector, fetch FSM
// states and the fetch buffer entry layout.
// Build option: IFETCH_SKID_BUFFER_EN selects a two-entry fetch buffer so
// fetch can keep going while the decoder stalls for one cycle. When it is
// undefined, the buffer holds a single entry.
package core_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

`ifdef IFETCH_SKID_BUFFER_EN
    localparam int IFETCH_DEPTH = 2;
`else
    localparam int IFETCH_DEPTH = 1;
`endif

    // F_REQ may issue, F_WAIT has a response outstanding, F_DROP has one
    // outstanding that must be thrown away, F_HOLD issues nothing.
    typedef enum logic [1:0] {
        F_REQ  = 2'd0,
        F_WAIT = 2'd1,
        F_DROP = 2'd2,
        F_HOLD = 2'd3
    } fetch_state_e;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Memory requests are always issued on a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel,
// redirect input from execute, and the decoder-facing instruction output.
// The master modport is the fetch unit; the slave modport is its
// environment (memory, execute stage and decoder).
interface instruction_fetch_if;
    import core_pkg::*;

    // Instruction memory channel
    logic            im_req;
    logic [XLEN-1:0] im_addr;
    logic            im_ready;
    logic            im_rvalid;
    logic [ILEN-1:0] im_rdata;

    // Control-flow redirect from branch, jump or MRET
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    // Decoder channel
    logic            inst_valid;
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;

    // Sticky misaligned-target flag
    logic            fetch_misaligned;

    modport master (
        output im_req,
        output im_addr,
        input  im_ready,
        input  im_rvalid,
        input  im_rdata,
        input  redirect,
        input  redirect_pc,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready,
        output fetch_misaligned
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ready,
        output im_rvalid,
        output im_rdata,
        output redirect,
        output redirect_pc,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready,
        input  fetch_misaligned
    );

endinterface

// File: rtl/instruction_fetch_buffer.sv
// fetch_buffer: small FIFO of fetched instructions sitting between the
// fetch FSM and the decoder. Supports push and pop in the same cycle even
// when full, and a single-cycle flush that discards every entry.
// The head is forced to zero while the buffer is empty so the decoder
// never sees stale data and the storage needs no reset.
module fetch_buffer
    import core_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head_entry,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    // Circular pointer advance that wraps at DEPTH (which need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    assign head_entry = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; flush empties the buffer outright.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are masked by empty so they carry no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: front end that walks the PC, keeps at most one
// instruction-memory request in flight and queues returned words for the
// decoder. A redirect reloads the PC, flushes the queue and, if a response
// is still in flight, marks it to be discarded when it lands.
// Build option: IFETCH_SKID_BUFFER_EN (see core_pkg) selects buffer depth 2
// instead of 1; nothing else changes.
module instruction_fetch
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);

    localparam int DEPTH = IFETCH_DEPTH;

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            misaligned_q;

    logic            im_req;
    logic            fire;
    logic            buf_push;
    logic            buf_pop;
    logic            buf_full;
    logic            buf_empty;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    // Issue only from F_REQ, never in a redirect cycle, never while the
    // misaligned flag is up and only with free space counted before any pop.
    assign im_req = !reset
                 && (state_q == F_REQ)
                 && !bus.redirect
                 && !misaligned_q
                 && !buf_full;
    assign fire   = im_req && bus.im_ready;

    // A response lands in the buffer only when it belongs to a live request.
    assign buf_push        = (state_q == F_WAIT) && bus.im_rvalid && !bus.redirect;
    assign push_entry.inst = bus.im_rdata;
    assign push_entry.pc   = req_pc_q;
    assign buf_pop         = !buf_empty && bus.inst_ready;

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .push       (buf_push),
        .push_entry (push_entry),
        .pop        (buf_pop),
        .flush      (bus.redirect),
        .head_entry (head_entry),
        .full       (buf_full),
        .empty      (buf_empty)
    );

    assign bus.im_req           = im_req;
    assign bus.im_addr          = word_align(pc_q);
    assign bus.inst_valid       = !buf_empty;
    assign bus.inst             = head_entry.inst;
    assign bus.inst_pc          = head_entry.pc;
    assign bus.fetch_misaligned = misaligned_q;

    // Fetch FSM with PC, in-flight request PC and sticky misaligned flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= F_REQ;
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else if (bus.redirect) begin
            pc_q         <= bus.redirect_pc;
            misaligned_q <= (bus.redirect_pc[1:0] != 2'b00);
            // A response still owed to us must be swallowed before issuing again.
            if (((state_q == F_WAIT) || (state_q == F_DROP)) && !bus.im_rvalid) begin
                state_q <= F_DROP;
            end else begin
                state_q <= F_REQ;
            end
        end else begin
            case (state_q)
                F_REQ: begin
                    if (fire) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + XLEN'(4);
                        state_q  <= F_WAIT;
                    end else if (buf_full || misaligned_q) begin
                        state_q <= F_HOLD;
                    end
                end
                F_WAIT: begin
                    if (bus.im_rvalid) begin
                        state_q <= F_REQ;
                    end
                end
                F_DROP: begin
                    if (bus.im_rvalid) begin
                        state_q <= F_REQ;
                    end
                end
                F_HOLD: begin
                    if (!buf_full && !misaligned_q) begin
                        state_q <= F_REQ;
                    end
                end
                default: state_q <= F_REQ;
            endcase
        end
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
REQ-002 Ports, in order:
  clk  in  1  single clock, all state updates on rising edge.
  reset  in  1  synchronous, active-high reset.
  im_req  out  1  instruction-memory request valid.
  im_addr  out  32  request byte address; always word-aligned.
  im_ready  in  1  memory accepts the request this cycle.
  im_rvalid  in  1  read data valid (one per accepted request).
  im_rdata  in  32  instruction word.
  redirect  in  1  PC redirect from branch, jump or MRET.
  redirect_pc  in  32  redirect target.
  inst_valid  out  1  buffer head holds a valid instruction for the decoder.
  inst  out  32  instruction word at buffer head.
  inst_pc  out  32  PC of inst.
  inst_ready  in  1  decoder consumes the head this cycle.
  fetch_misaligned  out  1  sticky flag: last redirect target had nonzero bits [1:0].

Function
REQ-003 The block SHALL keep at most one memory request outstanding.
REQ-004 FSM states SHALL be F_REQ (may issue), F_WAIT (outstanding), F_DROP (outstanding but discard) and F_HOLD (no issue).
REQ-005 im_req SHALL equal (state==F_REQ && !redirect && !fetch_misaligned && buffer count < DEPTH); a pop in the same cycle does not free space.
REQ-006 On im_req && im_ready, the block SHALL latch req_pc=pc, set pc=pc+4 (mod 2^32) and go to F_WAIT.
REQ-007 In F_REQ, if space is unavailable or fetch_misaligned is set, the block SHALL go to F_HOLD; it SHALL return to F_REQ when space exists and fetch_misaligned is clear.
REQ-008 In F_WAIT, im_rvalid without redirect SHALL push {im_rdata, req_pc} and go to F_REQ.
REQ-009 The push SHALL be registered: im_rvalid at cycle N gives inst_valid at N+1.
REQ-010 A redirect in any state SHALL set pc=redirect_pc, flush all buffer entries and suppress any push in that cycle.
  - State after redirect: F_DROP if a response is outstanding and not arriving this cycle, otherwise F_REQ.
REQ-011 In F_DROP, im_rvalid SHALL be discarded and the FSM SHALL go to F_REQ; a further redirect only updates pc.
REQ-012 A consumer handshake (inst_valid && inst_ready) in a redirect cycle SHALL complete; the remaining entries are flushed.
REQ-013 im_rvalid in F_REQ or F_HOLD SHALL be ignored.
REQ-014 A redirect with redirect_pc[1:0]!=0 SHALL set fetch_misaligned on the next cycle; the flag is cleared only by an aligned redirect.
REQ-015 im_addr SHALL equal {pc[31:2],2'b00}.
REQ-016 Buffer order SHALL be FIFO; a simultaneous push and pop on a full buffer SHALL be legal and keep count unchanged.

Reset
REQ-017 While reset is high, outputs SHALL be: im_req=0, im_addr=RESET_VECTOR, inst_valid=0, inst=0, inst_pc=0, fetch_misaligned=0.
  - Internal state: pc=RESET_VECTOR, state=F_REQ, buffer empty.
REQ-018 The first im_req SHALL assert in the first cycle after reset deasserts.
REQ-019 Reset mid-operation SHALL abandon any outstanding request; late responses are ignored under REQ-013.

Configuration
REQ-020 With macro IFETCH_SKID_BUFFER_EN defined, DEPTH SHALL be 2, allowing fetch to continue while the decoder stalls one cycle.
REQ-021 Without IFETCH_SKID_BUFFER_EN, DEPTH SHALL be 1; all other behaviour is unchanged.

Structure
REQ-022 The shared package core_pkg SHALL hold the FSM state enum, XLEN=32, the instruction width and the default reset vector.
REQ-023 The buffer SHALL be a sub-module fetch_buffer with parameter DEPTH and push, pop, flush, full and empty ports.

Verification
REQ-024 Reset release, im_ready=1, im_rvalid one cycle later with 0x00000013 -> im_addr 0x0, then 0x4; inst_valid with inst=0x00000013 and inst_pc=0x0 one cycle after rvalid.
REQ-025 inst_ready=0 held -> im_req drops after DEPTH pushes (1 or 2 per macro); releasing inst_ready drains in order with PCs 0x0, 0x4.
REQ-026 Redirect to 0x100 in F_WAIT, rvalid next cycle -> that data discarded, next im_addr=0x100, no stale inst_valid.
REQ-027 Redirect to 0x102 -> fetch_misaligned=1 next cycle, im_req stays 0; redirect to 0x200 -> flag clears, im_addr=0x200.
REQ-028 pc=0xFFFFFFFC fetched -> next im_addr=0x00000000.
REQ-029 Reset asserted in F_WAIT, rvalid arrives after release -> ignored; first inst_pc after reset = RESET_VECTOR.
